control_id: RTL and testbench

CONTROL_ID -- requirements
Module: control_id

---
 rtl/control_id.sv | 145 ++++++++++++++
 tb/tb_control_id.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_id.sv
// Instruction-decode control: opcode decode, vector/scalar register scoreboards,
// hazard detection with issue/stall, writeback strobes and stall statistics.
module control_id #(
    parameter int MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] instruccion,
    input  logic        inst_valid,
    input  logic        wb_valid,
    input  logic        wb_is_vec,
    input  logic [2:0]  wb_dir,
    output logic        reg_wrv,
    output logic        reg_wrs,
    output logic [2:0]  i_dir_wr,
    output logic        reg_rdv,
    output logic        reg_rds,
    output logic        sel_dest,
    output logic        stall,
    output logic        issue,
    output logic        illegal,
    output logic        wb_err,
    output logic [2:0]  outstanding,
    output logic [7:0]  stall_cnt
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_VADD = 4'b0001,
        OP_VSHL = 4'b0010,
        OP_VSCA = 4'b0011,
        OP_LIS  = 4'b0100,
        OP_VST  = 4'b0101
    } opcode_e;

    typedef enum logic {
        RUN,
        STALL
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  vbusy_q, vbusy_d;
    logic [7:0]  sbusy_q, sbusy_d;
    logic [2:0]  outstanding_q, outstanding_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic        wb_err_q, wb_err_d;

    logic        rd_va, rd_vb, rd_sb, dst_v, dst_s, bad_op, has_dest;
    logic [2:0]  dst_addr;
    logic [7:0]  wb_onehot, dst_onehot, wb_clr_v, wb_clr_s, vbusy_eff, sbusy_eff;
    logic        wb_hit, raw, waw, structural, hazard;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rd_va    = 1'b0;
        rd_vb    = 1'b0;
        rd_sb    = 1'b0;
        dst_v    = 1'b0;
        dst_s    = 1'b0;
        sel_dest = 1'b0;
        bad_op   = 1'b0;
        case (opcode_e'(instruccion[13:10]))
            OP_NOP:  ;
            OP_VADD: begin rd_va = 1'b1; rd_vb = 1'b1; dst_v = 1'b1; end
            OP_VSHL: begin rd_vb = 1'b1; dst_v = 1'b1; end
            OP_VSCA: begin rd_va = 1'b1; rd_sb = 1'b1; dst_v = 1'b1; end
            OP_LIS:  begin dst_s = 1'b1; sel_dest = 1'b1; end
            OP_VST:  rd_va = 1'b1;
            default: bad_op = 1'b1;
        endcase
        has_dest = dst_v | dst_s;
        dst_addr = sel_dest ? {1'b0, instruccion[9:8]} : instruccion[8:6];
    end

    always_comb begin
        wb_onehot  = 8'd1 << wb_dir;
        dst_onehot = 8'd1 << dst_addr;
        wb_clr_v   = (wb_valid && wb_is_vec)  ? wb_onehot : 8'd0;
        wb_clr_s   = (wb_valid && !wb_is_vec) ? wb_onehot : 8'd0;
        // A writeback landing this cycle already satisfies any consumer of that register.
        vbusy_eff  = vbusy_q & ~wb_clr_v;
        sbusy_eff  = sbusy_q & ~wb_clr_s;
        wb_hit     = wb_valid & (wb_is_vec ? vbusy_q[wb_dir] : sbusy_q[wb_dir]);

        raw        = (rd_va & vbusy_eff[instruccion[5:3]])
                   | (rd_vb & vbusy_eff[instruccion[2:0]])
                   | (rd_sb & sbusy_eff[instruccion[2:0]]);
        waw        = (dst_v & vbusy_eff[dst_addr]) | (dst_s & sbusy_eff[dst_addr]);
        structural = has_dest & (outstanding_q == 3'(MAX_OUT)) & ~wb_hit;
        hazard     = raw | waw | structural;

        stall      = ~rst & inst_valid & hazard;
        issue      = ~rst & inst_valid & ~hazard;
        illegal    = issue & bad_op;
        reg_rdv    = issue & (rd_va | rd_vb);
        reg_rds    = issue & rd_sb;

        reg_wrv    = wb_valid & wb_is_vec;
        reg_wrs    = wb_valid & ~wb_is_vec;
        i_dir_wr   = wb_dir;
    end

    always_comb begin
        // Clear before set so an issue and a writeback to the same bit leave it busy.
        vbusy_d = vbusy_q & ~wb_clr_v;
        sbusy_d = sbusy_q & ~wb_clr_s;
        if (issue && dst_v) vbusy_d = vbusy_d | dst_onehot;
        if (issue && dst_s) sbusy_d = sbusy_d | dst_onehot;

        outstanding_d = outstanding_q + {2'b00, issue & has_dest} - {2'b00, wb_hit};
        wb_err_d      = wb_err_q | (wb_valid & ~wb_hit);
        state_d       = stall ? STALL : RUN;

        stall_cnt_d = stall_cnt_q;
        case (state_q)
            RUN:   if (stall && stall_cnt_q != 8'hFF) stall_cnt_d = stall_cnt_q + 8'd1;
            STALL: if (stall && stall_cnt_q != 8'hFF) stall_cnt_d = stall_cnt_q + 8'd1;
            default: stall_cnt_d = stall_cnt_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            vbusy_q       <= 8'd0;
            sbusy_q       <= 8'd0;
            outstanding_q <= 3'd0;
            stall_cnt_q   <= 8'd0;
            wb_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            vbusy_q       <= vbusy_d;
            sbusy_q       <= sbusy_d;
            outstanding_q <= outstanding_d;
            stall_cnt_q   <= stall_cnt_d;
            wb_err_q      <= wb_err_d;
        end
    end

    assign outstanding = outstanding_q;
    assign stall_cnt   = stall_cnt_q;
    assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_control_id.sv
// Directed self-checking bench for control_id with hand-computed expectations.
module tb_control_id;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] instruccion;
    logic        inst_valid, wb_valid, wb_is_vec;
    logic [2:0]  wb_dir;
    logic        reg_wrv, reg_wrs, reg_rdv, reg_rds, sel_dest;
    logic        stall, issue, illegal, wb_err;
    logic [2:0]  i_dir_wr, outstanding;
    logic [7:0]  stall_cnt;

    int total = 0;
    int bad   = 0;

    control_id #(.MAX_OUT(4)) dut (
        .clk(clk), .rst(rst), .instruccion(instruccion), .inst_valid(inst_valid),
        .wb_valid(wb_valid), .wb_is_vec(wb_is_vec), .wb_dir(wb_dir),
        .reg_wrv(reg_wrv), .reg_wrs(reg_wrs), .i_dir_wr(i_dir_wr),
        .reg_rdv(reg_rdv), .reg_rds(reg_rds), .sel_dest(sel_dest),
        .stall(stall), .issue(issue), .illegal(illegal), .wb_err(wb_err),
        .outstanding(outstanding), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] mk(input logic [3:0] op, input logic [2:0] d,
                                       input logic [2:0] a, input logic [2:0] b);
        return {op, 1'b0, d, a, b};
    endfunction

    task automatic idle();
        inst_valid  = 1'b0;
        instruccion = 14'd0;
        wb_valid    = 1'b0;
        wb_is_vec   = 1'b0;
        wb_dir      = 3'd0;
    endtask

    task automatic inst(input logic [13:0] i);
        inst_valid  = 1'b1;
        instruccion = i;
    endtask

    task automatic wb(input logic vec, input logic [2:0] dir);
        wb_valid  = 1'b1;
        wb_is_vec = vec;
        wb_dir    = dir;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with live inputs: no issue, strobes still follow writeback inputs.
        rst = 1'b1;
        idle();
        inst(mk(4'h1, 3'd3, 3'd1, 3'd2));
        wb(1'b0, 3'd5);
        #1;
        check("rst_issue", issue, 0);
        check("rst_stall", stall, 0);
        check("rst_wrs", reg_wrs, 1);
        check("rst_wrv", reg_wrv, 0);
        check("rst_dir", i_dir_wr, 5);
        tick(); tick();
        rst = 1'b0;
        idle();
        #1;
        check("rst_out", outstanding, 0);
        check("rst_cnt", stall_cnt, 0);
        check("rst_err", wb_err, 0);

        // RAW stall resolved by same-cycle writeback.
        inst(mk(4'h1, 3'd3, 3'd1, 3'd2));
        #1;
        check("vadd_issue", issue, 1);
        check("vadd_rdv", reg_rdv, 1);
        check("vadd_rds", reg_rds, 0);
        check("vadd_sel", sel_dest, 0);
        tick();
        check("vadd_out", outstanding, 1);
        check("vadd_vbusy", dut.vbusy_q, 8'h08);
        inst(mk(4'h1, 3'd4, 3'd3, 3'd0));
        #1;
        check("raw_stall", stall, 1);
        check("raw_issue", issue, 0);
        check("raw_rdv", reg_rdv, 0);
        tick();
        check("raw_cnt1", stall_cnt, 1);
        tick();
        check("raw_cnt2", stall_cnt, 2);
        wb(1'b1, 3'd3);
        #1;
        check("raw_wb_issue", issue, 1);
        check("raw_wb_stall", stall, 0);
        check("raw_wb_wrv", reg_wrv, 1);
        check("raw_wb_dir", i_dir_wr, 3);
        tick();
        check("raw_cnt_hold", stall_cnt, 2);
        check("raw_out", outstanding, 1);
        check("raw_vbusy", dut.vbusy_q, 8'h10);
        idle();
        wb(1'b1, 3'd4);
        tick();
        check("clr_out0", outstanding, 0);

        // LIS s2,0x5A then a WAW on the same scalar.
        idle();
        inst(14'h125A);
        #1;
        check("lis_sel", sel_dest, 1);
        check("lis_issue", issue, 1);
        check("lis_rdv", reg_rdv, 0);
        tick();
        check("lis_sbusy", dut.sbusy_q, 8'h04);
        check("lis_out", outstanding, 1);
        #1;
        check("waw_stall", stall, 1);
        check("waw_sel", sel_dest, 1);
        tick();
        check("waw_cnt", stall_cnt, 3);
        idle();
        wb(1'b0, 3'd2);
        tick();
        check("lis_clr_out", outstanding, 0);
        check("lis_clr_err", wb_err, 0);

        // Structural limit at four outstanding writes.
        idle();
        for (int i = 0; i < 4; i++) begin
            inst(mk(4'h1, 3'(i), 3'd7, 3'd7));
            tick();
        end
        check("struct_out4", outstanding, 4);
        check("struct_vbusy", dut.vbusy_q, 8'h0F);
        inst(mk(4'h1, 3'd4, 3'd7, 3'd7));
        #1;
        check("struct_stall", stall, 1);
        tick();
        check("struct_cnt", stall_cnt, 4);
        wb(1'b1, 3'd0);
        #1;
        check("struct_wb_issue", issue, 1);
        tick();
        check("struct_out_keep", outstanding, 4);
        check("struct_vbusy2", dut.vbusy_q, 8'h1E);
        idle();
        inst(mk(4'h5, 3'd0, 3'd7, 3'd0));
        #1;
        check("vst_issue", issue, 1);
        check("vst_rdv", reg_rdv, 1);
        tick();
        check("vst_out", outstanding, 4);
        idle();
        for (int i = 1; i <= 4; i++) begin
            wb(1'b1, 3'(i));
            tick();
        end
        check("struct_drain", outstanding, 0);

        // Issue and writeback on the same vector register: set wins.
        idle();
        inst(mk(4'h1, 3'd5, 3'd7, 3'd7));
        tick();
        check("same_out1", outstanding, 1);
        wb(1'b1, 3'd5);
        #1;
        check("same_issue", issue, 1);
        tick();
        check("same_vbusy", dut.vbusy_q, 8'h20);
        check("same_out", outstanding, 1);
        idle();
        wb(1'b1, 3'd5);
        tick();
        check("same_drain", outstanding, 0);

        // VSCA waits on a busy scalar source.
        idle();
        inst({4'b0100, 2'b01, 8'h00});
        tick();
        check("lis1_sbusy", dut.sbusy_q, 8'h02);
        inst(mk(4'h3, 3'd6, 3'd2, 3'd1));
        #1;
        check("vsca_stall", stall, 1);
        check("vsca_rds0", reg_rds, 0);
        tick();
        check("vsca_cnt", stall_cnt, 5);
        wb(1'b0, 3'd1);
        #1;
        check("vsca_issue", issue, 1);
        check("vsca_rdv", reg_rdv, 1);
        check("vsca_rds", reg_rds, 1);
        tick();
        check("vsca_out", outstanding, 1);
        check("vsca_vbusy", dut.vbusy_q, 8'h40);
        idle();
        wb(1'b1, 3'd6);
        tick();
        check("vsca_drain", outstanding, 0);

        // Spurious scalar writeback.
        idle();
        wb(1'b0, 3'd7);
        #1;
        check("spur_wrs", reg_wrs, 1);
        check("spur_wrv", reg_wrv, 0);
        check("spur_dir", i_dir_wr, 7);
        tick();
        check("spur_err", wb_err, 1);
        check("spur_out", outstanding, 0);
        check("spur_sbusy", dut.sbusy_q, 8'h00);
        idle();
        tick();
        check("spur_sticky", wb_err, 1);

        // Illegal opcode.
        inst({4'hF, 10'h3FF});
        #1;
        check("ill_pulse", illegal, 1);
        check("ill_issue", issue, 1);
        check("ill_rdv", reg_rdv, 0);
        tick();
        check("ill_vbusy", dut.vbusy_q, 8'h00);
        check("ill_sbusy", dut.sbusy_q, 8'h00);
        check("ill_out", outstanding, 0);
        idle();
        #1;
        check("ill_end", illegal, 0);

        // Long stall saturates the counter, then reset mid-stall.
        inst(mk(4'h1, 3'd1, 3'd7, 3'd7));
        tick();
        inst(mk(4'h1, 3'd2, 3'd1, 3'd1));
        for (int i = 0; i < 300; i++) tick();
        check("sat_stall", stall, 1);
        check("sat_cnt", stall_cnt, 255);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", stall, 0);
        check("mid_rst_issue", issue, 0);
        tick();
        check("mid_rst_out", outstanding, 0);
        check("mid_rst_cnt", stall_cnt, 0);
        check("mid_rst_vbusy", dut.vbusy_q, 8'h00);
        check("mid_rst_err", wb_err, 0);
        rst = 1'b0;
        #1;
        check("post_rst_issue", issue, 1);
        check("post_rst_wrv", reg_wrv, 0);
        tick();
        check("post_rst_out", outstanding, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
